tcm_dec_symb_m_asm_nd: RTL and testbench
========================================

// Module: tcm_dec_symb_m_asm_nd
// PURPOSE
//  Generalised N-dimensional symbol metric assembler for the TCM decoder front end.
//  Collects per-8PSK-point metric/sign words at the i1sps strobe into groups of 1..pDIM_MAX points.
//  Group length is selectable at run time (2D/4D/8D trellis modes).
//  Emits one parallel group per oval to the branch metric unit; handles misframing and short final groups.
// PARAMETERS
//  pSYMB_M_W  8  metric bit width inside symb_m_t (package typedef)
//  pDIM_MAX   8  max points per group, 2..8; output array depth
// PORTS
//  iclk          in   1                 clock
//  ireset        in   1                 async reset, active-high
//  iclkena       in   1                 clock enable; low freezes all state
//  i1sps         in   1                 point strobe; all i* below qualified by it
//  idim          in   $clog2(pDIM_MAX)+1  group length N, 1..pDIM_MAX, sampled with ival
//  isop          in   1                 frame start
//  ival          in   1                 first point of a group
//  ieop          in   1                 frame end (last point)
//  isymb_m       in   symb_m_t          point metrics
//  isymb_m_sign  in   symb_m_sign_t     point metric signs
//  osop          out  1                 frame start, valid with oval
//  oval          out  1                 group complete, 1-cycle pulse
//  oeop          out  1                 frame end, valid with oval
//  odim          out  $clog2(pDIM_MAX)+1  N of emitted group
//  opad          out  1                 group zero-padded (short at eop), valid with oval
//  oerr          out  1                 1-cycle pulse: partial group discarded
//  osymb_m       out  symb_m_t [pDIM_MAX]       [0]=first point; slots >=odim are zero
//  osymb_m_sign  out  symb_m_sign_t [pDIM_MAX]  same ordering
// BEHAVIOUR
//  - Reset: osop/oval/oeop/opad/oerr=0, cnt=0, busy=0, odim=pDIM_MAX; data regs not reset.
//  - All state updates require iclkena; point actions additionally require i1sps.
//  - ival point: latch N=idim, clear all slots to 0, write slot 0, cnt=1, busy=1.
//  - Non-ival point with busy: write slot cnt, cnt+=1. Non-ival point with !busy is dropped.
//  - Indexed write only, no shift, so any N works.
//  - Group done when the written point is slot N-1, or on ieop with busy.
//  - oval asserts the next clock; cnt=0, busy=0. Latency 1 clk from last point.
//  - N=1: the ival point itself completes the group.
//  - ieop before slot N-1: emit with remaining slots zero, opad=1.
//  - ival while busy and cnt<N: oerr pulse; partial group discarded (no oval); new group starts with that point.
//  - osop: set on isop point, held until the oval that carries it, then cleared.
//    A new isop on the oval clock re-arms it. oeop follows the same rule.
//  - idim=0 or >pDIM_MAX: clamped to pDIM_MAX.
//  - idim change mid-group is ignored until the next ival.
//  - osymb_m/odim/opad hold their value between ovals.
//  - ireset mid-group: partial group lost, outputs zeroed immediately.
// STRUCTURE
//  - Package tcm_dec_types: symb_m_t, symb_m_sign_t, cDIM_W=$clog2(pDIM_MAX)+1.
//  - Package tcm_dec_types also holds the clamp function dim_clamp().
//  - One natural sub-module: tcm_dec_asm_ctrl (cnt/busy/N FSM: IDLE/FILL).
//    It produces the write index, done, pad and err; the top holds the slot registers.
// TESTING
//  1. N=4; 8 points with ival on points 0,4; metrics 1..8.
//     -> 2 ovals; group0 slots = 1,2,3,4; group1 slots = 5,6,7,8; odim=4, slots 4..7 = 0.
//  2. N=8, isop on pt0, ieop on pt7.
//     -> single oval with osop=1 and oeop=1; next group has osop=0.
//  3. N=4, ieop on 2nd point of group.
//     -> oval 1 clk later; slots = a,b,0,0; opad=1.
//  4. N=4, ival again after 3 points.
//     -> oerr pulse, no oval for the partial group; next group completes normally.
//  5. Switch idim 2->8 mid-group, i1sps every 3rd clk, iclkena toggled.
//     -> old group emits at 2 points; new length applies from next ival; timing frozen while iclkena=0.
//  6. Assert ireset after 2 of 4 points.
//     -> all outputs 0 at once; stray points after release are dropped until ival.

Source files
------------

// File: rtl/tcm_dec_symb_m_asm_nd_pkg.sv
// Shared types and helpers for the TCM decoder symbol metric assembler.
package tcm_dec_types;

    localparam int pSYMB_M_W = 8;                    // metric width per point
    localparam int cSIGN_W   = 3;                    // one sign bit per 8PSK label bit
    localparam int cDIM_MAX  = 8;                    // largest supported group length
    localparam int cDIM_W    = $clog2(cDIM_MAX) + 1; // wide enough to hold cDIM_MAX itself

    typedef logic [pSYMB_M_W-1:0] symb_m_t;
    typedef logic [cSIGN_W-1:0]   symb_m_sign_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } asm_state_t;

    // Out-of-range group lengths (0 or above the maximum) fall back to the maximum.
    function automatic logic [cDIM_W-1:0] dim_clamp(input logic [cDIM_W-1:0] d,
                                                    input logic [cDIM_W-1:0] dmax);
        if (d == '0 || d > dmax)
            return dmax;
        return d;
    endfunction

endpackage

// File: rtl/tcm_dec_symb_m_asm_nd_ctrl.sv
// Group framing control: tracks fill count, group length and busy state and
// tells the top which slot to write and when a group is complete.
module tcm_dec_asm_ctrl
    import tcm_dec_types::*;
#(
    parameter int pDIM_MAX = cDIM_MAX
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              i_ena,
    input  logic              i_pt,
    input  logic              i_val,
    input  logic              i_eop,
    input  logic [cDIM_W-1:0] i_dim,
    output logic              o_we,
    output logic              o_clr,
    output logic [cDIM_W-1:0] o_widx,
    output logic              o_done,
    output logic              o_pad,
    output logic              o_err,
    output logic [cDIM_W-1:0] o_n
);

    localparam logic [cDIM_W-1:0] lpDIM_MAX = cDIM_W'(pDIM_MAX);

    asm_state_t        r_state, w_state_next;
    logic [cDIM_W-1:0] r_cnt, w_cnt_next;
    logic [cDIM_W-1:0] r_n, w_n_next;
    logic [cDIM_W-1:0] w_n_new;
    logic [cDIM_W-1:0] w_last;

    // State, fill count and latched group length; frozen while the clock enable is low.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_n     <= lpDIM_MAX;
        end else if (i_ena) begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_n     <= w_n_next;
        end
    end

    // Point handling: a group start restarts at slot 0 (flagging any abandoned
    // partial group); otherwise points append while busy and are dropped when idle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_n_next     = r_n;
        w_n_new      = dim_clamp(i_dim, lpDIM_MAX);
        w_last       = r_n - cDIM_W'(1);
        o_we         = 1'b0;
        o_clr        = 1'b0;
        o_widx       = r_cnt;
        o_done       = 1'b0;
        o_pad        = 1'b0;
        o_err        = 1'b0;
        o_n          = r_n;
        if (i_ena && i_pt) begin
            if (i_val) begin
                o_we     = 1'b1;
                o_clr    = 1'b1;
                o_widx   = '0;
                o_n      = w_n_new;
                o_err    = (r_state == ST_FILL);
                w_n_next = w_n_new;
                if (w_n_new == cDIM_W'(1) || i_eop) begin
                    o_done       = 1'b1;
                    o_pad        = (w_n_new != cDIM_W'(1));
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_state_next = ST_FILL;
                    w_cnt_next   = cDIM_W'(1);
                end
            end else if (r_state == ST_FILL) begin
                o_we = 1'b1;
                if (r_cnt == w_last || i_eop) begin
                    o_done       = 1'b1;
                    o_pad        = (r_cnt != w_last);
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + cDIM_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tcm_dec_symb_m_asm_nd.sv
// N-dimensional symbol metric assembler: gathers per-point metrics into
// groups of 1..pDIM_MAX points and presents each complete group in parallel.
module tcm_dec_symb_m_asm_nd
    import tcm_dec_types::*;
#(
    parameter int pDIM_MAX = cDIM_MAX
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic              i1sps,
    input  logic [cDIM_W-1:0] idim,
    input  logic              isop,
    input  logic              ival,
    input  logic              ieop,
    input  symb_m_t           isymb_m,
    input  symb_m_sign_t      isymb_m_sign,
    output logic              osop,
    output logic              oval,
    output logic              oeop,
    output logic [cDIM_W-1:0] odim,
    output logic              opad,
    output logic              oerr,
    output symb_m_t           osymb_m      [pDIM_MAX],
    output symb_m_sign_t      osymb_m_sign [pDIM_MAX]
);

    logic              w_we, w_clr, w_done, w_pad, w_err;
    logic [cDIM_W-1:0] w_widx, w_n;

    symb_m_t      r_buf_m [pDIM_MAX];
    symb_m_sign_t r_buf_s [pDIM_MAX];
    symb_m_t      w_slot_m [pDIM_MAX];
    symb_m_sign_t w_slot_s [pDIM_MAX];

    logic              r_osop, r_oval, r_oeop, r_opad, r_oerr;
    logic [cDIM_W-1:0] r_odim;
    logic              r_sop_arm, r_eop_arm;

    tcm_dec_asm_ctrl #(.pDIM_MAX(pDIM_MAX)) u_ctrl (
        .iclk   (iclk),
        .ireset (ireset),
        .i_ena  (iclkena),
        .i_pt   (i1sps),
        .i_val  (ival),
        .i_eop  (ieop),
        .i_dim  (idim),
        .o_we   (w_we),
        .o_clr  (w_clr),
        .o_widx (w_widx),
        .o_done (w_done),
        .o_pad  (w_pad),
        .o_err  (w_err),
        .o_n    (w_n)
    );

    for (genvar gi = 0; gi < pDIM_MAX; gi++) begin : g_slot
        // Slot view including the point arriving this clock, so a completing
        // point lands in the output together with the earlier ones.
        always_comb begin
            w_slot_m[gi] = r_buf_m[gi];
            w_slot_s[gi] = r_buf_s[gi];
            if (w_widx == cDIM_W'(gi)) begin
                w_slot_m[gi] = isymb_m;
                w_slot_s[gi] = isymb_m_sign;
            end else if (w_clr) begin
                w_slot_m[gi] = '0;
                w_slot_s[gi] = '0;
            end
        end

        // Working buffer: indexed write only, cleared wholesale at a group start.
        always_ff @(posedge iclk) begin
            if (w_we) begin
                r_buf_m[gi] <= w_slot_m[gi];
                r_buf_s[gi] <= w_slot_s[gi];
            end
        end

        // Output slots update only when a group completes and hold otherwise.
        always_ff @(posedge iclk or posedge ireset) begin
            if (ireset) begin
                osymb_m[gi]      <= '0;
                osymb_m_sign[gi] <= '0;
            end else if (w_done) begin
                osymb_m[gi]      <= w_slot_m[gi];
                osymb_m_sign[gi] <= w_slot_s[gi];
            end
        end
    end

    // Group flags: frame markers are armed by accepted points and consumed by the emitting group.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            r_oval    <= 1'b0;
            r_oerr    <= 1'b0;
            r_osop    <= 1'b0;
            r_oeop    <= 1'b0;
            r_opad    <= 1'b0;
            r_odim    <= cDIM_W'(pDIM_MAX);
            r_sop_arm <= 1'b0;
            r_eop_arm <= 1'b0;
        end else if (iclkena) begin
            r_oval    <= w_done;
            r_oerr    <= w_err;
            r_osop    <= w_done & (r_sop_arm | isop);
            r_oeop    <= w_done & (r_eop_arm | ieop);
            r_sop_arm <= w_done ? 1'b0 : (r_sop_arm | (w_we & isop));
            r_eop_arm <= w_done ? 1'b0 : (r_eop_arm | (w_we & ieop));
            if (w_done) begin
                r_odim <= w_n;
                r_opad <= w_pad;
            end
        end
    end

    assign osop = r_osop;
    assign oval = r_oval;
    assign oeop = r_oeop;
    assign odim = r_odim;
    assign opad = r_opad;
    assign oerr = r_oerr;

endmodule

// File: tb/tb_tcm_dec_symb_m_asm_nd.sv
// Directed bench for the symbol metric assembler: a vector table of single
// point transactions plus hand sequences for enable, strobe and reset corners.
module tb_tcm_dec_symb_m_asm_nd;
    import tcm_dec_types::*;

    logic         iclk = 1'b0;
    logic         ireset = 1'b1;
    logic         iclkena = 1'b0;
    logic         i1sps = 1'b0;
    logic [3:0]   idim = 4'd4;
    logic         isop = 1'b0, ival = 1'b0, ieop = 1'b0;
    symb_m_t      isymb_m = '0;
    symb_m_sign_t isymb_m_sign = '0;
    logic         osop, oval, oeop, opad, oerr;
    logic [3:0]   odim;
    symb_m_t      osymb_m [8];
    symb_m_sign_t osymb_m_sign [8];

    int total = 0;
    int bad = 0;

    tcm_dec_symb_m_asm_nd #(.pDIM_MAX(8)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .i1sps(i1sps),
        .idim(idim), .isop(isop), .ival(ival), .ieop(ieop),
        .isymb_m(isymb_m), .isymb_m_sign(isymb_m_sign),
        .osop(osop), .oval(oval), .oeop(oeop), .odim(odim), .opad(opad),
        .oerr(oerr), .osymb_m(osymb_m), .osymb_m_sign(osymb_m_sign)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic       v, sop, eop;
        logic [3:0] dim;
        logic [7:0] m;
        logic       xval, xerr, xsop, xeop, xpad;
        logic [3:0] xdim;
        logic [63:0] xm;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(logic v, logic sop, logic eop, logic [3:0] dim, logic [7:0] m,
                                 logic xval, logic xerr, logic xsop, logic xeop, logic xpad,
                                 logic [3:0] xdim, logic [63:0] xm);
        vec_t r;
        r.v = v; r.sop = sop; r.eop = eop; r.dim = dim; r.m = m;
        r.xval = xval; r.xerr = xerr; r.xsop = xsop; r.xeop = xeop; r.xpad = xpad;
        r.xdim = xdim; r.xm = xm;
        return r;
    endfunction

    function automatic logic [63:0] got_m();
        logic [63:0] g = '0;
        for (int i = 0; i < 8; i++) g[i*8 +: 8] = osymb_m[i];
        return g;
    endfunction

    function automatic logic [63:0] got_s();
        logic [63:0] g = '0;
        for (int i = 0; i < 8; i++) g[i*3 +: 3] = osymb_m_sign[i];
        return g;
    endfunction

    // Signs are driven as the low three bits of each metric.
    function automatic logic [63:0] exp_s(logic [63:0] xm);
        logic [63:0] g = '0;
        for (int i = 0; i < 8; i++) g[i*3 +: 3] = xm[i*8 +: 3];
        return g;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(logic ena, logic sps, logic v, logic sop, logic eop,
                        logic [3:0] dim, logic [7:0] m);
        iclkena = ena; i1sps = sps; ival = v; isop = sop; ieop = eop;
        idim = dim; isymb_m = m; isymb_m_sign = m[2:0];
        @(posedge iclk);
        #1;
        $display("step ena=%0b sps=%0b val=%0b sop=%0b eop=%0b dim=%0d m=%h -> oval=%0b oerr=%0b odim=%0d",
                 ena, sps, v, sop, eop, dim, m, oval, oerr, odim);
    endtask

    task automatic chk_group(string nm, logic xsop, logic xeop, logic xpad,
                             logic [3:0] xdim, logic [63:0] xm);
        chk({nm, ".oval"}, 64'(oval), 64'd1);
        chk({nm, ".osop"}, 64'(osop), 64'(xsop));
        chk({nm, ".oeop"}, 64'(oeop), 64'(xeop));
        chk({nm, ".opad"}, 64'(opad), 64'(xpad));
        chk({nm, ".odim"}, 64'(odim), 64'(xdim));
        chk({nm, ".slots"}, got_m(), xm);
        chk({nm, ".signs"}, got_s(), exp_s(xm));
    endtask

    initial begin
        // 1: N=4, two full groups
        tbl.push_back(row(1,0,0,4,8'h01, 0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,4,8'h02, 0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,4,8'h03, 0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,4,8'h04, 1,0,0,0,0,4,64'h04030201));
        tbl.push_back(row(1,0,0,4,8'h05, 0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,4,8'h06, 0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,4,8'h07, 0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,4,8'h08, 1,0,0,0,0,4,64'h08070605));
        // 2: N=8 framed group, then an unframed N=2 group
        tbl.push_back(row(1,1,0,8,8'h11, 0,0,0,0,0,0,0));
        for (int k = 2; k <= 7; k++)
            tbl.push_back(row(0,0,0,8,8'(8'h10 + k), 0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,1,8,8'h18, 1,0,1,1,0,8,64'h1817161514131211));
        tbl.push_back(row(1,0,0,2,8'h21, 0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,2,8'h22, 1,0,0,0,0,2,64'h2221));
        // 3: short final group padded
        tbl.push_back(row(1,0,0,4,8'h31, 0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,1,4,8'h32, 1,0,0,1,1,4,64'h3231));
        // 4: restart mid-group discards the partial one
        tbl.push_back(row(1,0,0,4,8'h41, 0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,4,8'h42, 0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,4,8'h43, 0,0,0,0,0,0,0));
        tbl.push_back(row(1,0,0,4,8'h51, 0,1,0,0,0,0,0));
        tbl.push_back(row(0,0,0,4,8'h52, 0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,4,8'h53, 0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,4,8'h54, 1,0,0,0,0,4,64'h54535251));
        // N=1 groups back to back, second carrying sop on its only point
        tbl.push_back(row(1,0,0,1,8'h61, 1,0,0,0,0,1,64'h61));
        tbl.push_back(row(1,1,0,1,8'h62, 1,0,1,0,0,1,64'h62));
        // clamping of 0 and >8; mid-group dim change ignored
        tbl.push_back(row(1,0,0,0,8'h71, 0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,1,0,8'h72, 1,0,0,1,1,8,64'h7271));
        tbl.push_back(row(1,0,0,15,8'h73, 0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,3,8'h74, 0,0,0,0,0,0,0));
        tbl.push_back(row(0,0,1,3,8'h75, 1,0,0,1,1,8,64'h757473));
        // stray point while idle is dropped
        tbl.push_back(row(0,0,0,4,8'h99, 0,0,0,0,0,0,0));

        // reset state
        repeat (3) @(posedge iclk);
        #1;
        chk("rst.oval", 64'(oval), 0);
        chk("rst.oerr", 64'(oerr), 0);
        chk("rst.osop", 64'(osop), 0);
        chk("rst.oeop", 64'(oeop), 0);
        chk("rst.opad", 64'(opad), 0);
        chk("rst.odim", 64'(odim), 64'd8);
        chk("rst.slots", got_m(), 0);
        ireset = 1'b0;

        foreach (tbl[i]) begin
            step(1, 1, tbl[i].v, tbl[i].sop, tbl[i].eop, tbl[i].dim, tbl[i].m);
            chk($sformatf("v%0d.oval", i), 64'(oval), 64'(tbl[i].xval));
            chk($sformatf("v%0d.oerr", i), 64'(oerr), 64'(tbl[i].xerr));
            if (tbl[i].xval)
                chk_group($sformatf("v%0d", i), tbl[i].xsop, tbl[i].xeop, tbl[i].xpad,
                          tbl[i].xdim, tbl[i].xm);
        end

        // 5: sparse strobe, enable gaps, dim switch 2->8 mid-group
        step(1, 1, 1, 0, 0, 4'd2, 8'h81);
        chk("t5.first", 64'(oval), 0);
        step(1, 0, 0, 0, 0, 4'd8, 8'h00);
        step(0, 1, 1, 0, 0, 4'd8, 8'hEE);
        chk("t5.frozen_err", 64'(oerr), 0);
        step(1, 1, 0, 0, 0, 4'd8, 8'h82);
        chk_group("t5.g0", 0, 0, 0, 4'd2, 64'h8281);
        step(0, 0, 0, 0, 0, 4'd8, 8'h00);
        chk("t5.oval_frozen", 64'(oval), 1);
        step(1, 0, 0, 0, 0, 4'd8, 8'h00);
        chk("t5.oval_drop", 64'(oval), 0);
        step(1, 1, 1, 0, 0, 4'd8, 8'h91);
        step(1, 0, 0, 0, 0, 4'd8, 8'h00);
        step(1, 0, 0, 0, 0, 4'd8, 8'h00);
        step(1, 1, 0, 0, 0, 4'd8, 8'h92);
        step(1, 0, 0, 0, 0, 4'd8, 8'h00);
        step(0, 1, 0, 0, 1, 4'd8, 8'hEE);
        chk("t5.frozen_eop", 64'(oval), 0);
        step(1, 1, 0, 0, 1, 4'd8, 8'h93);
        chk_group("t5.g1", 0, 1, 1, 4'd8, 64'h939291);

        // 6: reset mid-group
        step(1, 1, 1, 0, 0, 4'd4, 8'hA1);
        step(1, 1, 0, 0, 0, 4'd4, 8'hA2);
        #2 ireset = 1'b1;
        #1;
        chk("t6.oval", 64'(oval), 0);
        chk("t6.odim", 64'(odim), 64'd8);
        chk("t6.opad", 64'(opad), 0);
        chk("t6.slots", got_m(), 0);
        chk("t6.signs", got_s(), 0);
        #2 ireset = 1'b0;
        step(1, 1, 0, 0, 0, 4'd4, 8'hA3);
        chk("t6.stray0", 64'(oval), 0);
        step(1, 1, 0, 0, 0, 4'd4, 8'hA4);
        chk("t6.stray1", 64'(oval), 0);
        step(1, 1, 1, 0, 0, 4'd4, 8'hB1);
        step(1, 1, 0, 0, 0, 4'd4, 8'hB2);
        step(1, 1, 0, 0, 0, 4'd4, 8'hB3);
        step(1, 1, 0, 0, 0, 4'd4, 8'hB4);
        chk_group("t6.g", 0, 0, 0, 4'd4, 64'hB4B3B2B1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
